// File: rtl/pipe_stage_reg_perf_pkg.sv
// Shared CPU pipeline definitions: the control-field layout carried between
// stages, default widths, and the stall-source index map.
package cpu_pipe_pkg;

  // Control field for one pipeline slot. All-zero is the bubble encoding,
  // so every side-effect bit must be active-high.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       mem_to_reg;
    logic [4:0] rsvd;
  } ctrl_t;

  localparam int CTRL_W_DEF = $bits(ctrl_t);
  localparam int CNT_W_DEF  = 64;

  // Stall-source bit positions in the stall vector
  localparam int STALL_IM = 0;
  localparam int STALL_DM = 1;

endpackage

// File: rtl/pipe_stage_reg_perf_if.sv
// Handshake bundle between pipeline and one stage register.
//   master : pipeline side, drives stall/flush/in_*, reads out_*
//   slave  : stage register, reads stall/flush/in_*, drives out_*
interface pipe_stage_reg_perf_if
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int STALL_N = 2
) ();

  logic [STALL_N-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output stall, flush, in_valid, in_ctrl, in_data,
    input  out_valid, out_ctrl, out_data
  );

  modport slave (
    input  stall, flush, in_valid, in_ctrl, in_data,
    output out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_perf_counter.sv
// perf_counter: free-running wrap-around event counter.
//   clk, reset (async, active low)
//   clr : synchronous clear, wins over inc
//   inc : count one event this edge
//   cnt : current count
module perf_counter
  import cpu_pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg_perf.sv
// pipe_stage_reg_perf: one pipeline stage register (IF/ID .. MEM/WB) plus the
// stage's performance counters.
//   clk, reset      : clock, async active-low reset
//   p (slave)       : stall vector, flush, in_valid/ctrl/data, out_valid/ctrl/data
//   cnt_clr         : synchronous clear of all counters
//   cycle_cnt       : cycles since reset/clear
//   instret_cnt     : accepted instructions once past the warm-up window
//   stall_cnt       : cycles with any stall source active
//   flush_cnt       : flushes that took effect (not masked by a stall)
// Update priority each edge: stall > flush > load. Outputs are all registered.
module pipe_stage_reg_perf
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                STALL_N  = 2,
  parameter int                CNT_W    = CNT_W_DEF,
  parameter int                WARMUP   = 4,
  parameter bit                COUNT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  pipe_stage_reg_perf_if.slave p,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  logic              stall_any;
  logic              flush_eff;
  logic              accept;
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  assign stall_any = |p.stall;
  assign flush_eff = p.flush & ~stall_any;
  assign accept    = p.in_valid & ~stall_any & ~p.flush;

  // Flush only kills valid/ctrl; data is left alone so the wide payload
  // does not toggle on a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      data_q  <= '0;
    end else if (stall_any) begin
      valid_q <= valid_q;
      ctrl_q  <= ctrl_q;
      data_q  <= data_q;
    end else if (p.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end else begin
      valid_q <= p.in_valid;
      ctrl_q  <= p.in_valid ? p.in_ctrl : CTRL_NOP;
      data_q  <= p.in_data;
    end
  end

  assign p.out_valid = valid_q;
  assign p.out_ctrl  = ctrl_q;
  assign p.out_data  = data_q;

  generate
    if (COUNT_EN) begin : g_cnt
      localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);
      logic instret_inc;

      // Warm-up compares the pre-increment cycle count, so it reapplies
      // after a clear and after cycle_cnt wraps.
      assign instret_inc = accept & (cycle_cnt >= WARMUP_C);

      perf_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk(clk), .reset(reset), .clr(cnt_clr), .inc(1'b1), .cnt(cycle_cnt));
      perf_counter #(.CNT_W(CNT_W)) u_instret (
        .clk(clk), .reset(reset), .clr(cnt_clr), .inc(instret_inc), .cnt(instret_cnt));
      perf_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .reset(reset), .clr(cnt_clr), .inc(stall_any), .cnt(stall_cnt));
      perf_counter #(.CNT_W(CNT_W)) u_flush (
        .clk(clk), .reset(reset), .clr(cnt_clr), .inc(flush_eff), .cnt(flush_cnt));
    end else begin : g_no_cnt
      logic unused_cnt;
      assign unused_cnt  = ^{accept, flush_eff, cnt_clr};
      assign cycle_cnt   = '0;
      assign instret_cnt = '0;
      assign stall_cnt   = '0;
      assign flush_cnt   = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg_perf.sv
module tb_pipe_stage_reg_perf;
  import cpu_pipe_pkg::*;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             reset;
  logic             cnt_clr;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg_perf_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STALL_N(2)) bus ();

  pipe_stage_reg_perf #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(16'h0000), .STALL_N(2),
    .CNT_W(CNT_W), .WARMUP(4), .COUNT_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .p(bus.slave), .cnt_clr(cnt_clr),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] c, input logic [127:0] d);
    chk({tag, ".valid"}, 128'(bus.out_valid), 128'(v));
    chk({tag, ".ctrl"},  128'(bus.out_ctrl),  128'(c));
    chk({tag, ".data"},  bus.out_data,        d);
  endtask

  task automatic chk_cnt(input string tag, input int cy, input int ir, input int st, input int fl);
    chk({tag, ".cycle"},   128'(cycle_cnt),   128'(cy));
    chk({tag, ".instret"}, 128'(instret_cnt), 128'(ir));
    chk({tag, ".stall"},   128'(stall_cnt),   128'(st));
    chk({tag, ".flush"},   128'(flush_cnt),   128'(fl));
  endtask

  initial begin
    reset        = 1'b0;
    cnt_clr      = 1'b0;
    bus.stall    = '0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    bus.in_data  = '0;

    // reset held 2 cycles
    step(); step();
    chk_out("reset", 1'b0, 16'h0, 128'h0);
    chk_cnt("reset", 0, 0, 0, 0);
    reset = 1'b1;

    // first load; cycle_cnt was 0 so no instret
    bus.in_valid = 1'b1; bus.in_ctrl = 16'h00A5; bus.in_data = 128'h1234;
    step();
    chk_out("load", 1'b1, 16'h00A5, 128'h1234);
    chk_cnt("load", 1, 0, 0, 0);

    // async reset mid-stream, observed before any edge
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 16'h0, 128'h0);
    chk("async_rst.cycle", 128'(cycle_cnt), 128'd0);
    reset = 1'b1;

    // warm-up: edges with pre-count 0..3 do not count
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 128'(i);
      step();
      if (i == 3) chk("warm4.instret", 128'(instret_cnt), 128'd0);
      if (i == 4) chk("warm5.instret", 128'(instret_cnt), 128'd1);
    end
    chk_cnt("warm10", 10, 6, 0, 0);
    chk_out("warm10", 1'b1, 16'h00A5, 128'h9);

    // stall from source 1 for 3 cycles while inputs change
    bus.stall = 2'b10; bus.in_ctrl = 16'h0033; bus.in_data = 128'h7777;
    step(); step(); step();
    chk_out("stall3", 1'b1, 16'h00A5, 128'h9);
    chk_cnt("stall3", 13, 6, 3, 0);

    // load BEEF, then flush with 5555 on the input
    bus.stall = 2'b00; bus.in_ctrl = 16'h00A5; bus.in_data = 128'hBEEF;
    step();
    chk_out("beef", 1'b1, 16'h00A5, 128'hBEEF);
    bus.flush = 1'b1; bus.in_data = 128'h5555;
    step();
    chk_out("flush", 1'b0, 16'h0, 128'hBEEF);
    chk_cnt("flush", 15, 7, 3, 1);

    // real slot in, cycle_cnt wraps 15 -> 0
    bus.flush = 1'b0; bus.in_ctrl = 16'h005A; bus.in_data = 128'hCAFE;
    step();
    chk_out("cafe", 1'b1, 16'h005A, 128'hCAFE);
    chk_cnt("cafe", 0, 8, 3, 1);

    // stall beats flush
    bus.stall = 2'b01; bus.flush = 1'b1; bus.in_data = 128'h6666;
    step();
    chk_out("stall_flush", 1'b1, 16'h005A, 128'hCAFE);
    chk_cnt("stall_flush", 1, 8, 4, 1);

    // stall drops, flush still high -> bubble
    bus.stall = 2'b00;
    step();
    chk_out("flush_after", 1'b0, 16'h0, 128'hCAFE);
    chk_cnt("flush_after", 2, 8, 4, 2);

    // stall + flush + clear together: stage holds, counters all zero
    bus.stall = 2'b10; bus.flush = 1'b1; cnt_clr = 1'b1;
    bus.in_ctrl = 16'h0011; bus.in_data = 128'h9999;
    step();
    chk_out("clr", 1'b0, 16'h0, 128'hCAFE);
    chk_cnt("clr", 0, 0, 0, 0);

    // 17 idle cycles: cycle wraps to 1, invalid slot gives NOP ctrl
    bus.stall = 2'b00; bus.flush = 1'b0; cnt_clr = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk_out("wrap", 1'b0, 16'h0, 128'h9999);
    chk_cnt("wrap", 1, 0, 0, 0);

    // after wrap the warm-up window applies again
    bus.in_valid = 1'b1;
    step();
    chk_out("rewarm", 1'b1, 16'h0011, 128'h9999);
    chk_cnt("rewarm", 2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
